// File: rtl/conv_row_fetch_gen.sv
// conv_row_fetch_gen
// Walks the output rows of one input-feature-map plane and issues parallel row
// reads to ROWS independent pixel banks. It handles vertical padding, stride,
// horizontal chunking and kernel heights below ROWS. Returned rows are assembled
// into windows and delivered through a credit-managed show-ahead FIFO.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   start           begin a plane (sampled only while idle); config latched then
//   k, s, p         kernel height, vertical stride, top padding rows
//   iy, oy          input rows, output rows
//   row_words       chunks per input row
//   base_adr        bank address of input row 0, chunk 0
//   busy, done      plane in progress / one-cycle completion pulse
//   rd_en, rd_adr   per-bank registered read enable and address
//   rd_data         bank data, valid RD_LAT cycles after rd_en
//   win_*           window stream (valid/ready), rows, row mask and position
module conv_row_fetch_gen #(
  parameter int ROWS       = 3,
  parameter int PIXELS     = 32,
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [3:0]                   k,
  input  logic [3:0]                   s,
  input  logic [3:0]                   p,
  input  logic [15:0]                  iy,
  input  logic [15:0]                  oy,
  input  logic [15:0]                  row_words,
  input  logic [ADDR_W-1:0]            base_adr,
  output logic                         busy,
  output logic                         done,
  output logic [ROWS-1:0]              rd_en,
  output logic [ROWS*ADDR_W-1:0]       rd_adr,
  input  logic [ROWS*PIXELS*PIX_W-1:0] rd_data,
  output logic                         win_valid,
  input  logic                         win_ready,
  output logic [ROWS*PIXELS*PIX_W-1:0] win_rows,
  output logic [ROWS-1:0]              win_row_mask,
  output logic [15:0]                  win_oy,
  output logic [15:0]                  win_chunk,
  output logic                         win_last
);

  localparam int ROW_W = PIXELS * PIX_W;
  localparam int WIN_W = ROWS * ROW_W;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PIPE  = RD_LAT + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_r, state_n;

  // latched plane configuration
  logic [3:0]        k_r, s_r, p_r;
  logic [15:0]       iy_r, oy_r, rw_r;
  logic [ADDR_W-1:0] base_r;

  // loop position of the next window to issue
  logic [15:0] oy_i_r, chunk_r;

  // metadata travelling alongside the bank reads
  logic            pipe_v_r     [PIPE];
  logic [ROWS-1:0] pipe_mask_r  [PIPE];
  logic [15:0]     pipe_oy_r    [PIPE];
  logic [15:0]     pipe_chunk_r [PIPE];
  logic            pipe_last_r  [PIPE];

  // window FIFO
  logic [WIN_W-1:0] fifo_rows_r  [FIFO_DEPTH];
  logic [ROWS-1:0]  fifo_mask_r  [FIFO_DEPTH];
  logic [15:0]      fifo_oy_r    [FIFO_DEPTH];
  logic [15:0]      fifo_chunk_r [FIFO_DEPTH];
  logic             fifo_last_r  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;

  logic              cfg_bad_s;
  logic [15:0]       in_flight_s;
  logic              credit_ok_s;
  logic              last_pos_s;
  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_nonempty_s;
  logic [17:0]       row_base_s;
  logic [17:0]       r_s   [ROWS];
  logic [ROWS-1:0]   real_s;
  logic [ADDR_W-1:0] adr_s [ROWS];
  logic [WIN_W-1:0]  push_rows_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign cfg_bad_s       = (oy == 16'd0) || (row_words == 16'd0) || (k == 4'd0);
  assign last_pos_s      = (oy_i_r == oy_r - 16'd1) && (chunk_r == rw_r - 16'd1);
  // a window holds its credit from issue until it is popped from the FIFO
  assign credit_ok_s     = (in_flight_s + 16'(cnt_r)) < 16'(FIFO_DEPTH);
  assign issue_s         = (state_r == ST_RUN) && credit_ok_s;
  assign push_s          = pipe_v_r[RD_LAT];
  assign fifo_nonempty_s = (cnt_r != '0);
  assign pop_s           = fifo_nonempty_s && win_ready;

  // count windows whose reads are still in flight
  always_comb begin
    in_flight_s = 16'd0;
    for (int i = 0; i < PIPE; i++) begin
      in_flight_s = in_flight_s + {15'd0, pipe_v_r[i]};
    end
  end

  // per-bank input row, validity and address for the current position
  always_comb begin
    row_base_s = 18'(oy_i_r) * 18'(s_r);
    for (int kr = 0; kr < ROWS; kr++) begin
      // 18-bit two's complement: negative means the row lies in the top pad
      r_s[kr]    = row_base_s + 18'(kr) - 18'(p_r);
      real_s[kr] = (4'(kr) < k_r) && !r_s[kr][17] && (r_s[kr][16:0] < {1'b0, iy_r});
      if (real_s[kr]) begin
        adr_s[kr] = base_r + ADDR_W'(32'(r_s[kr][15:0]) * 32'(rw_r)) + ADDR_W'(chunk_r);
      end else begin
        adr_s[kr] = '0;
      end
    end
  end

  // next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (cfg_bad_s) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_RUN;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s && last_pos_s) begin
          state_n = ST_DRAIN;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if ((in_flight_s == 16'd0) && !fifo_nonempty_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // state register and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_n;
      busy    <= (state_n != ST_IDLE);
      done    <= (state_n == ST_DONE);
    end
  end

  // configuration capture on an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_r    <= 4'd0;
      s_r    <= 4'd0;
      p_r    <= 4'd0;
      iy_r   <= 16'd0;
      oy_r   <= 16'd0;
      rw_r   <= 16'd0;
      base_r <= '0;
    end else if ((state_r == ST_IDLE) && start) begin
      k_r    <= k;
      s_r    <= s;
      p_r    <= p;
      iy_r   <= iy;
      oy_r   <= oy;
      rw_r   <= row_words;
      base_r <= base_adr;
    end
  end

  // loop counters: chunk inner, output row outer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oy_i_r  <= 16'd0;
      chunk_r <= 16'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      oy_i_r  <= 16'd0;
      chunk_r <= 16'd0;
    end else if (issue_s) begin
      if (chunk_r == rw_r - 16'd1) begin
        chunk_r <= 16'd0;
        oy_i_r  <= oy_i_r + 16'd1;
      end else begin
        chunk_r <= chunk_r + 16'd1;
      end
    end
  end

  // registered bank read port, idle (all zero) on non-issue cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en  <= '0;
      rd_adr <= '0;
    end else begin
      rd_en <= issue_s ? real_s : '0;
      for (int kr = 0; kr < ROWS; kr++) begin
        rd_adr[kr*ADDR_W +: ADDR_W] <= issue_s ? adr_s[kr] : '0;
      end
    end
  end

  // metadata shift pipeline; last stage lines up with rd_data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIPE; i++) begin
        pipe_v_r[i]     <= 1'b0;
        pipe_mask_r[i]  <= '0;
        pipe_oy_r[i]    <= 16'd0;
        pipe_chunk_r[i] <= 16'd0;
        pipe_last_r[i]  <= 1'b0;
      end
    end else begin
      pipe_v_r[0]     <= issue_s;
      pipe_mask_r[0]  <= real_s;
      pipe_oy_r[0]    <= oy_i_r;
      pipe_chunk_r[0] <= chunk_r;
      pipe_last_r[0]  <= last_pos_s;
      for (int i = 1; i < PIPE; i++) begin
        pipe_v_r[i]     <= pipe_v_r[i-1];
        pipe_mask_r[i]  <= pipe_mask_r[i-1];
        pipe_oy_r[i]    <= pipe_oy_r[i-1];
        pipe_chunk_r[i] <= pipe_chunk_r[i-1];
        pipe_last_r[i]  <= pipe_last_r[i-1];
      end
    end
  end

  // zero the rows that are padding or beyond the kernel before buffering
  always_comb begin
    push_rows_s = '0;
    for (int kr = 0; kr < ROWS; kr++) begin
      if (pipe_mask_r[RD_LAT][kr]) begin
        push_rows_s[kr*ROW_W +: ROW_W] = rd_data[kr*ROW_W +: ROW_W];
      end else begin
        push_rows_s[kr*ROW_W +: ROW_W] = '0;
      end
    end
  end

  // FIFO pointers and occupancy; credits guarantee no push when full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // FIFO storage; contents are only visible while occupied, so no reset needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_rows_r[wr_ptr_r]  <= push_rows_s;
      fifo_mask_r[wr_ptr_r]  <= pipe_mask_r[RD_LAT];
      fifo_oy_r[wr_ptr_r]    <= pipe_oy_r[RD_LAT];
      fifo_chunk_r[wr_ptr_r] <= pipe_chunk_r[RD_LAT];
      fifo_last_r[wr_ptr_r]  <= pipe_last_r[RD_LAT];
    end
  end

  // show-ahead window outputs, forced to zero while the FIFO is empty
  always_comb begin
    win_valid = fifo_nonempty_s;
    if (fifo_nonempty_s) begin
      win_rows     = fifo_rows_r[rd_ptr_r];
      win_row_mask = fifo_mask_r[rd_ptr_r];
      win_oy       = fifo_oy_r[rd_ptr_r];
      win_chunk    = fifo_chunk_r[rd_ptr_r];
      win_last     = fifo_last_r[rd_ptr_r];
    end else begin
      win_rows     = '0;
      win_row_mask = '0;
      win_oy       = 16'd0;
      win_chunk    = 16'd0;
      win_last     = 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_row_fetch_gen.sv
// Scoreboard bench for conv_row_fetch_gen: directed planes push hand-computed
// windows into a queue, a monitor pops and compares each accepted window.
module tb_conv_row_fetch_gen;
  localparam int ROWS       = 3;
  localparam int PIXELS     = 32;
  localparam int PIX_W      = 8;
  localparam int ADDR_W     = 16;
  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int ROW_W      = PIXELS * PIX_W;
  localparam int WIN_W      = ROWS * ROW_W;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic [3:0]             k = 4'd0, s = 4'd0, p = 4'd0;
  logic [15:0]            iy = 16'd0, oy = 16'd0, row_words = 16'd0;
  logic [ADDR_W-1:0]      base_adr = '0;
  logic                   busy, done;
  logic [ROWS-1:0]        rd_en;
  logic [ROWS*ADDR_W-1:0] rd_adr;
  logic [WIN_W-1:0]       rd_data = '0;
  logic                   win_valid;
  logic                   win_ready = 1'b0;
  logic [WIN_W-1:0]       win_rows;
  logic [ROWS-1:0]        win_row_mask;
  logic [15:0]            win_oy, win_chunk;
  logic                   win_last;

  conv_row_fetch_gen #(
    .ROWS(ROWS), .PIXELS(PIXELS), .PIX_W(PIX_W), .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .k(k), .s(s), .p(p),
    .iy(iy), .oy(oy), .row_words(row_words), .base_adr(base_adr),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_adr(rd_adr), .rd_data(rd_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_rows(win_rows),
    .win_row_mask(win_row_mask), .win_oy(win_oy), .win_chunk(win_chunk),
    .win_last(win_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       mask;
    logic [15:0]      oy;
    logic [15:0]      chunk;
    logic             last;
    logic [WIN_W-1:0] rows;
  } win_t;

  win_t exp_q [$];
  win_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bad_en2 = 0;
  int   bad_deg = 0;
  bit   chk_en2 = 1'b0;
  bit   chk_deg = 1'b0;

  // bank content: distinct per bank and per address
  function automatic logic [ROW_W-1:0] word_of(input int j, input logic [15:0] a);
    logic [ROW_W-1:0] w;
    for (int x = 0; x < PIXELS; x++) begin
      w[x*PIX_W +: PIX_W] = 8'(int'(a) * 3 + (int'(a) >> 8) * 29 + x * 5 + j * 64 + 1);
    end
    return w;
  endfunction

  // bank memory model with RD_LAT=1; idle banks return junk so masking shows
  always @(posedge clk) begin
    for (int j = 0; j < ROWS; j++) begin
      if (rd_en[j]) rd_data[j*ROW_W +: ROW_W] <= word_of(j, rd_adr[j*ADDR_W +: ADDR_W]);
      else          rd_data[j*ROW_W +: ROW_W] <= {PIXELS{8'hA5}};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [2:0] m, input logic [15:0] o, input logic [15:0] c,
                          input logic l, input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] a2);
    win_t e;
    logic [15:0] a [3];
    a[0] = a0; a[1] = a1; a[2] = a2;
    e.mask = m; e.oy = o; e.chunk = c; e.last = l; e.rows = '0;
    for (int j = 0; j < 3; j++) begin
      if (m[j]) e.rows[j*ROW_W +: ROW_W] = word_of(j, a[j]);
    end
    exp_q.push_back(e);
  endtask

  // k=3 s=1 p=1 iy=4 oy=4 row_words=2 base=0x100
  task automatic push_case1();
    push_exp(3'b110, 16'd0, 16'd0, 1'b0, 16'h000, 16'h100, 16'h102);
    push_exp(3'b110, 16'd0, 16'd1, 1'b0, 16'h000, 16'h101, 16'h103);
    push_exp(3'b111, 16'd1, 16'd0, 1'b0, 16'h100, 16'h102, 16'h104);
    push_exp(3'b111, 16'd1, 16'd1, 1'b0, 16'h101, 16'h103, 16'h105);
    push_exp(3'b111, 16'd2, 16'd0, 1'b0, 16'h102, 16'h104, 16'h106);
    push_exp(3'b111, 16'd2, 16'd1, 1'b0, 16'h103, 16'h105, 16'h107);
    push_exp(3'b011, 16'd3, 16'd0, 1'b0, 16'h104, 16'h106, 16'h000);
    push_exp(3'b011, 16'd3, 16'd1, 1'b1, 16'h105, 16'h107, 16'h000);
  endtask

  task automatic set_cfg(input logic [3:0] kk, input logic [3:0] ss, input logic [3:0] pp,
                         input logic [15:0] iyy, input logic [15:0] oyy,
                         input logic [15:0] rww, input logic [15:0] bb);
    k = kk; s = ss; p = pp; iy = iyy; oy = oyy; row_words = rww; base_adr = bb;
  endtask

  task automatic start_plane(input logic [3:0] kk, input logic [3:0] ss, input logic [3:0] pp,
                             input logic [15:0] iyy, input logic [15:0] oyy,
                             input logic [15:0] rww, input logic [15:0] bb);
    @(posedge clk); #1;
    set_cfg(kk, ss, pp, iyy, oyy, rww, bb);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s_done: got no done pulse within %0d cycles, required one", name, budget);
    end else begin
      @(negedge clk);
      check({name, "_pulse_width"}, 64'(done), 64'(0));
      check({name, "_busy_after"}, 64'(busy), 64'(0));
    end
  endtask

  // scoreboard monitor: compare every accepted window
  always @(negedge clk) begin
    if (reset && win_valid && win_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL win_extra: got window oy=%0d chunk=%0d, required none", win_oy, win_chunk);
      end else begin
        mon_e = exp_q.pop_front();
        if (win_row_mask !== mon_e.mask || win_oy !== mon_e.oy || win_chunk !== mon_e.chunk ||
            win_last !== mon_e.last || win_rows !== mon_e.rows) begin
          n_bad++;
          $display("FAIL win_data: got mask=%b oy=%0d chunk=%0d last=%b rows_ok=%0d r0=%h r1=%h r2=%h, required mask=%b oy=%0d chunk=%0d last=%b r0=%h r1=%h r2=%h",
                   win_row_mask, win_oy, win_chunk, win_last, win_rows === mon_e.rows,
                   win_rows[31:0], win_rows[ROW_W +: 32], win_rows[2*ROW_W +: 32],
                   mon_e.mask, mon_e.oy, mon_e.chunk, mon_e.last,
                   mon_e.rows[31:0], mon_e.rows[ROW_W +: 32], mon_e.rows[2*ROW_W +: 32]);
        end
      end
    end
  end

  // property watchers for specific tests
  always @(negedge clk) begin
    if (chk_en2 && rd_en[2]) bad_en2++;
    if (chk_deg && (rd_en != '0 || win_valid)) bad_deg++;
  end

  initial begin
    int issued;
    int lat;
    bit seen;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({busy, done, rd_en, win_valid, win_row_mask, win_last}), 64'(0));
    check("rst_adr", 64'(rd_adr), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    // basic padding case
    win_ready = 1'b1;
    push_case1();
    start_plane(4'd3, 4'd1, 4'd1, 16'd4, 16'd4, 16'd2, 16'h100);
    check("case1_busy", 64'(busy), 64'(1));
    wait_done("case1", 100);
    check("case1_sb_empty", 64'(exp_q.size()), 64'(0));

    // stride with short kernel
    chk_en2 = 1'b1;
    push_exp(3'b011, 16'd0, 16'd0, 1'b0, 16'h000, 16'h001, 16'h000);
    push_exp(3'b011, 16'd1, 16'd0, 1'b1, 16'h002, 16'h003, 16'h000);
    start_plane(4'd2, 4'd2, 4'd0, 16'd4, 16'd2, 16'd1, 16'h000);
    wait_done("case2", 100);
    chk_en2 = 1'b0;
    check("case2_rd_en2_cycles", 64'(bad_en2), 64'(0));
    check("case2_sb_empty", 64'(exp_q.size()), 64'(0));

    // backpressure: consumer stalls for 10 cycles
    win_ready = 1'b0;
    push_case1();
    start_plane(4'd3, 4'd1, 4'd1, 16'd4, 16'd4, 16'd2, 16'h100);
    issued = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rd_en != '0) issued++;
    end
    check("bp_issued", 64'(issued), 64'(FIFO_DEPTH));
    check("bp_rd_en_idle", 64'(rd_en), 64'(0));
    check("bp_valid_held", 64'(win_valid), 64'(1));
    @(posedge clk); #1;
    win_ready = 1'b1;
    wait_done("bp", 100);
    check("bp_sb_empty", 64'(exp_q.size()), 64'(0));

    // degenerate plane oy=0
    chk_deg = 1'b1;
    @(posedge clk); #1;
    set_cfg(4'd3, 4'd1, 4'd1, 16'd4, 16'd0, 16'd2, 16'h100);
    start = 1'b1;
    @(negedge clk);
    lat = 1;
    seen = done;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
    check("deg_done_lat", 64'(lat), 64'(2));
    @(negedge clk);
    check("deg_pulse_width", 64'(done), 64'(0));
    repeat (3) @(negedge clk);
    chk_deg = 1'b0;
    check("deg_no_rd_or_valid", 64'(bad_deg), 64'(0));

    // reset mid-plane with windows buffered
    win_ready = 1'b0;
    push_case1();
    start_plane(4'd3, 4'd1, 4'd1, 16'd4, 16'd4, 16'd2, 16'h100);
    repeat (5) @(negedge clk);
    check("mid_valid_before_rst", 64'({busy, win_valid}), 64'(3));
    reset = 1'b0;
    #1;
    check("mid_rst_ctrl", 64'({busy, done, rd_en, win_valid, win_row_mask, win_last}), 64'(0));
    check("mid_rst_adr", 64'(rd_adr), 64'(0));
    check("mid_rst_meta", 64'({win_oy, win_chunk}), 64'(0));
    check("mid_rst_rows", 64'(win_rows != '0), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    win_ready = 1'b1;
    push_case1();
    start_plane(4'd3, 4'd1, 4'd1, 16'd4, 16'd4, 16'd2, 16'h100);
    wait_done("after_rst", 100);
    check("after_rst_sb_empty", 64'(exp_q.size()), 64'(0));

    // start while busy must be ignored
    push_case1();
    start_plane(4'd3, 4'd1, 4'd1, 16'd4, 16'd4, 16'd2, 16'h100);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    set_cfg(4'd2, 4'd2, 4'd0, 16'd4, 16'd2, 16'd1, 16'h000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start", 100);
    check("busy_start_sb_empty", 64'(exp_q.size()), 64'(0));
    repeat (5) @(negedge clk);
    check("busy_start_no_replay", 64'({busy, win_valid}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
